multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT, default 0, range 0-15: extra wait cycles added to every memory-access state.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 instr_op  input  6  opcode from instruction register; sampled only in DECODE.
REQ-005 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write  output  1 each  PC/memory/IR enables and select.
REQ-006 mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  register-file and ALU-A selects.
REQ-007 alu_src_b, alu_op, pc_source  output  2 each  ALU-B select, ALU-control opcode (00 add, 01 sub, 10 funct), PC mux select.
REQ-008 state  output  4  current state encoding, debug only.
REQ-009 illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-010 States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11; codes 12-15 go to FETCH on the next edge.
REQ-011 Outputs are Moore (state plus wait counter only); any output not listed for a state is 0.
REQ-012 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=1 and pc_write=1 only in the final FETCH cycle.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by instr_op: 000000 EXECUTE, 100011/101011 MEM_ADDR, 000100 BRANCH, 000010 JUMP, 001000 ADDI_EX, others FETCH with illegal=1 in this cycle.
REQ-014 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_READ if opcode latched in DECODE is 100011, else MEM_WRITE.
REQ-015 MEM_READ: mem_read=1, i_or_d=1; then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-016 MEM_WRITE: mem_write=1, i_or_d=1, held for every cycle of the state; then FETCH.
REQ-017 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-018 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH.
REQ-019 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-020 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-021 Memory states (FETCH, MEM_READ, MEM_WRITE) last exactly MEM_WAIT+1 cycles: a 4-bit counter loads 0 on entry, increments each cycle, and the state exits when counter == MEM_WAIT.
REQ-022 Non-memory states last exactly one cycle.
REQ-023 The opcode class is latched in DECODE; instr_op changes after DECODE do not affect the path.
REQ-024 Cycle counts per instruction (MEM_WAIT=W): lw 5+2W, sw 4+2W, R-type 4+W, addi 4+W, beq 3+W, j 3+W, illegal 2+W.

Reset
REQ-025 rst sampled high at a rising edge: state<=FETCH, wait counter<=0, latched opcode<=000000.
REQ-026 While rst is high, pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, illegal are forced 0; other outputs hold FETCH values.
REQ-027 Reset asserted mid-instruction (including mid-wait) aborts it; the first cycle after rst falls is FETCH with counter 0.

Verification
REQ-028 MEM_WAIT=0, lw (100011) -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; 5 cycles.
REQ-029 MEM_WAIT=0, sw then R-type -> sw: 0,1,2,5 with mem_write=1 only in 5; R: 0,1,6,7 with alu_op=10 in 6 and reg_dst=1 in 7.
REQ-030 MEM_WAIT=0, beq and j -> beq: 0,1,8 with pc_write_cond=1, alu_op=01; j: 0,1,9 with pc_write=1, pc_source=10.
REQ-031 MEM_WAIT=2, lw -> FETCH 3 cycles with ir_write/pc_write only in the 3rd, MEM_READ 3 cycles; 9 cycles total.
REQ-032 Opcode 111111 -> 0,1,0; illegal=1 for exactly the DECODE cycle; no write enables asserted.
REQ-033 MEM_WAIT=3, rst pulsed during second MEM_WRITE cycle -> mem_write=0 in reset cycle; next cycle state=0, new fetch lasts 4 cycles.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle processor main control unit.
// Moore-style FSM with a wait counter that stretches every memory-access
// state (FETCH, MEM_READ, MEM_WRITE) to MEM_WAIT+1 cycles. The opcode is
// captured in DECODE so later changes on instr_op cannot alter the path.
module multicycle_control #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] instr_op,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Counter value on the final cycle of a memory state.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;
    logic [5:0] op_reg;
    logic [5:0] op_next;
    logic       wait_done;
    logic       mem_state;
    logic       op_legal;

    assign wait_done = (wait_cnt_reg == WAIT_LAST);
    assign mem_state = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                       (state_reg == S_MEM_WRITE);
    assign op_legal  = (instr_op == OP_RTYPE) || (instr_op == OP_LW) ||
                       (instr_op == OP_SW) || (instr_op == OP_BEQ) ||
                       (instr_op == OP_J) || (instr_op == OP_ADDI);
    assign state     = state_reg;

    // State, wait counter and latched opcode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= 4'd0;
            op_reg       <= 6'b000000;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            op_reg       <= op_next;
        end
    end

    // Next-state selection, wait counting and opcode capture.
    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        // The counter restarts at 0 whenever a state is entered; it only
        // advances while a memory state is still waiting.
        wait_cnt_next = (mem_state && !wait_done) ? wait_cnt_reg + 4'd1 : 4'd0;
        case (state_reg)
            S_FETCH: begin
                if (wait_done) state_next = S_DECODE;
            end
            S_DECODE: begin
                op_next = instr_op;
                case (instr_op)
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_next = (op_reg == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (wait_done) state_next = S_MEM_WB;
            end
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: begin
                if (wait_done) state_next = S_FETCH;
            end
            S_EXECUTE:   state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_ADDI_EX:   state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    // Control outputs decoded from state and wait counter; reset masks all
    // enables and parks the selects on their FETCH values.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // PC and IR update once, when the memory data is ready.
                ir_write  = wait_done;
                pc_write  = wait_done;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal   = !op_legal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            illegal       = 1'b0;
            i_or_d        = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b01;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
        end
    end

endmodule
